// File: rtl/asrm_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : asrm_bus_arbiter
// Purpose  : Two-master round-robin arbiter for the asrm system bus.
//            Grants follow registered state only. A tenure is bounded while
//            the other master waits. The granted master is muxed onto the bus,
//            and read data is fanned back to both masters.
// Revision : 1.0  initial release
// ============================================================================
module asrm_bus_arbiter #(
  parameter int WORDSIZE = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0,
  input  logic [WORDSIZE-1:0] addr0,
  input  logic                we0,
  input  logic [WORDSIZE-1:0] wdata0,
  output logic                gnt0,
  input  logic                req1,
  input  logic [WORDSIZE-1:0] addr1,
  input  logic                we1,
  input  logic [WORDSIZE-1:0] wdata1,
  output logic                gnt1,
  output logic [WORDSIZE-1:0] bus_addr,
  output logic                bus_we,
  output logic [WORDSIZE-1:0] bus_wdata,
  input  logic [WORDSIZE-1:0] bus_rdata,
  output logic [WORDSIZE-1:0] rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_t;

  // A single-cycle tenure limit still needs a 1-bit counter.
  localparam int            CW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic          last_q, last_d;
  logic          other_waiting;

  // Next-state selection, tenure counter and round-robin pointer update.
  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    last_d        = last_q;
    other_waiting = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req0 && req1) begin
          state_d = last_q ? ST_GNT0 : ST_GNT1;
        end else if (req0) begin
          state_d = ST_GNT0;
        end else if (req1) begin
          state_d = ST_GNT1;
        end
      end
      ST_GNT0: begin
        other_waiting = req1;
        if (!req0) begin
          state_d = req1 ? ST_GNT1 : ST_IDLE;
        end else if (req1 && (hold_cnt_q == HOLD_LAST)) begin
          state_d = ST_GNT1;
        end
      end
      ST_GNT1: begin
        other_waiting = req0;
        if (!req1) begin
          state_d = req0 ? ST_GNT0 : ST_IDLE;
        end else if (req0 && (hold_cnt_q == HOLD_LAST)) begin
          state_d = ST_GNT0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The counter only measures how long the other master has been kept waiting.
    if (state_d != state_q) begin
      hold_cnt_d = '0;
    end else if (other_waiting) begin
      hold_cnt_d = (hold_cnt_q == HOLD_LAST) ? hold_cnt_q : hold_cnt_q + CW'(1);
    end else begin
      hold_cnt_d = '0;
    end

    if ((state_d != state_q) && (state_d == ST_GNT0)) begin
      last_d = 1'b0;
    end else if ((state_d != state_q) && (state_d == ST_GNT1)) begin
      last_d = 1'b1;
    end
  end

  // State registers. Reset leaves last=1 so master 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      last_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      last_q     <= last_d;
    end
  end

  assign gnt0  = (state_q == ST_GNT0);
  assign gnt1  = (state_q == ST_GNT1);
  assign rdata = bus_rdata;

  // Bus mux. Write enable is also qualified by req, so a master that drops
  // out mid-cycle cannot issue a stray write.
  always_comb begin
    bus_addr  = '0;
    bus_we    = 1'b0;
    bus_wdata = '0;
    case (state_q)
      ST_GNT0: begin
        bus_addr  = addr0;
        bus_we    = we0 & req0;
        bus_wdata = wdata0;
      end
      ST_GNT1: begin
        bus_addr  = addr1;
        bus_we    = we1 & req1;
        bus_wdata = wdata1;
      end
      default: begin
        bus_addr  = '0;
        bus_we    = 1'b0;
        bus_wdata = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_asrm_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_asrm_bus_arbiter
// Purpose  : Directed bench for asrm_bus_arbiter (MAX_HOLD=8 main instance
//            plus a MAX_HOLD=1 instance sharing the same stimulus).
// Revision : 1.0  initial release
// ============================================================================
module tb_asrm_bus_arbiter;

  typedef struct packed {
    logic       g0;
    logic       g1;
    logic [7:0] addr;
    logic       we;
    logic [7:0] wdata;
    logic [7:0] rd;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [7:0] addr0 = 8'h00, addr1 = 8'h00, wdata0 = 8'h00, wdata1 = 8'h00;
  logic [7:0] bus_rdata = 8'h3C;
  logic       gnt0, gnt1, bus_we;
  logic [7:0] bus_addr, bus_wdata, rdata;
  logic       h1_gnt0, h1_gnt1, h1_bus_we;
  logic [7:0] h1_bus_addr, h1_bus_wdata, h1_rdata;

  int   total = 0;
  int   bad   = 0;
  obs_t sb[$];

  always #5 clk = ~clk;

  asrm_bus_arbiter #(.WORDSIZE(8), .MAX_HOLD(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .we0(we0), .wdata0(wdata0), .gnt0(gnt0),
    .req1(req1), .addr1(addr1), .we1(we1), .wdata1(wdata1), .gnt1(gnt1),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .rdata(rdata)
  );

  asrm_bus_arbiter #(.WORDSIZE(8), .MAX_HOLD(1)) dut_h1 (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .we0(we0), .wdata0(wdata0), .gnt0(h1_gnt0),
    .req1(req1), .addr1(addr1), .we1(we1), .wdata1(wdata1), .gnt1(h1_gnt1),
    .bus_addr(h1_bus_addr), .bus_we(h1_bus_we), .bus_wdata(h1_bus_wdata),
    .bus_rdata(bus_rdata), .rdata(h1_rdata)
  );

  // Change requests away from the active edge.
  task automatic drive(input logic r0, input logic r1);
    @(negedge clk);
    req0 = r0;
    req1 = r1;
  endtask

  // Push the expected bus view for the coming edge, then pop and compare.
  task automatic chk(input string tag, input logic g0, input logic g1);
    obs_t e, o;
    e.g0    = g0;
    e.g1    = g1;
    e.addr  = g0 ? addr0  : (g1 ? addr1  : 8'h00);
    e.we    = g0 ? (we0 & req0) : (g1 ? (we1 & req1) : 1'b0);
    e.wdata = g0 ? wdata0 : (g1 ? wdata1 : 8'h00);
    e.rd    = bus_rdata;
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = '{gnt0, gnt1, bus_addr, bus_we, bus_wdata, rdata};
    e = sb.pop_front();
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    addr0 = 8'h11; we0 = 1'b1; wdata0 = 8'h22;
    addr1 = 8'h80; we1 = 1'b1; wdata1 = 8'hA5;

    // Held in reset with both masters requesting: nothing granted.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1);
      chk("reset_hold", 1'b0, 1'b0);
    end

    // Release: master 0 wins the first tie, then 8/8 alternation.
    // The MAX_HOLD=1 instance must alternate every cycle.
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i != 0) drive(1'b1, 1'b1);
      chk("rr_hold8", ((i / 8) % 2) == 0, ((i / 8) % 2) == 1);
      chk_bit("h1_gnt0", h1_gnt0, (i % 2) == 0);
      chk_bit("h1_gnt1", h1_gnt1, (i % 2) == 1);
    end

    // Master 1 backs off: master 0 stays and its tenure counter restarts.
    drive(1'b1, 1'b0);
    chk("gnt0_alone", 1'b1, 1'b0);

    // Simultaneous drop of req0 / rise of req1: no write from we0, direct hand-over.
    drive(1'b0, 1'b1);
    #1;
    chk_bit("drop_gnt0_still", gnt0, 1'b1);
    chk_bit("drop_we_masked", bus_we, 1'b0);
    chk("handover_gnt1", 1'b0, 1'b1);

    // Everyone drops: IDLE with a zero bus and read data still fanned out.
    drive(1'b0, 1'b0);
    chk("idle", 1'b0, 1'b0);

    // Lone master 1 from IDLE, then keeps the bus indefinitely.
    drive(1'b0, 1'b1);
    chk("req1_only", 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b1);
      chk("lone_gnt1", 1'b0, 1'b1);
    end

    // Reset mid-tenure with master 0 now waiting.
    drive(1'b1, 1'b1);
    reset = 1'b0;
    chk("reset_mid", 1'b0, 1'b0);
    drive(1'b1, 1'b1);
    reset = 1'b1;
    chk("post_reset_gnt0", 1'b1, 1'b0);

    // Return to IDLE with last=0: a tie must now go to master 1.
    drive(1'b0, 1'b0);
    chk("idle2", 1'b0, 1'b0);
    drive(1'b1, 1'b1);
    chk("tie_last0", 1'b0, 1'b1);

    // Master 1 read-only tenure, different read data on the bus.
    we1 = 1'b0;
    bus_rdata = 8'h5A;
    drive(1'b1, 1'b1);
    chk("gnt1_read", 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
